// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage program-counter generator.
package pc_pkg;

    // Default PC width and the default reset vector
    localparam int          PC_WIDTH_DEF = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    // PC word at the default width
    typedef logic [PC_WIDTH_DEF-1:0] pc_word_t;

    // Source selected for the next pc value, in priority order
    typedef enum logic [1:0] {
        REDIRECT = 2'd0,
        RAS      = 2'd1,
        SEQ      = 2'd2,
        HOLD     = 2'd3
    } pc_src_e;

endpackage

// File: rtl/pc_gen_ras_stack.sv
// Circular return-address stack. A push onto a full stack overwrites
// the oldest entry. Pops on an empty stack are ignored. When a push and an
// effective pop happen in the same cycle, top_data still shows the
// pre-push top and the push overwrites that same slot.
module ras_stack #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 32,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] top_data,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] top_q, top_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop_eff;

    // Next pointer, count and storage for push, pop or push+pop
    always_comb begin
        mem_d   = mem_q;
        top_d   = top_q;
        count_d = count_q;
        pop_eff = pop && (count_q != '0);
        case ({push, pop_eff})
            2'b10: begin
                top_d        = top_q + PTR_W'(1);
                mem_d[top_d] = push_data;
                count_d      = (count_q == FULL) ? count_q : count_q + CNT_W'(1);
            end
            2'b01: begin
                top_d   = top_q - PTR_W'(1);
                count_d = count_q - CNT_W'(1);
            end
            2'b11: begin
                mem_d[top_q] = push_data;
            end
            default: ;
        endcase
    end

    // Pointer and count registers; reset empties the stack
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            top_q   <= '0;
            count_q <= '0;
        end else begin
            top_q   <= top_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are don't-care after reset
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign top_data = mem_q[top_q];
    assign count    = count_q;

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator with redirect port and RAS prediction.
//
// Handshake: pc is offered whenever pc_valid=1; a fetch transfer happens on
// each rising edge where pc_valid=1 and fetch_ready=1, after which pc moves on
// (sequentially or to the RAS top). Without fetch_ready the pc holds, except
// for a redirect, which replaces pc unconditionally.
module pc_gen
    import pc_pkg::*;
#(
    parameter int               WIDTH     = PC_WIDTH_DEF,
    parameter int               STEP      = 1,
    parameter logic [WIDTH-1:0] RESET_PC  = WIDTH'(RESET_PC_DEF),
    parameter int               RAS_DEPTH = 4
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         fetch_ready,
    output logic                         pc_valid,
    output logic [WIDTH-1:0]             pc,
    output logic [WIDTH-1:0]             pc_next_seq,
    input  logic                         redirect_valid,
    input  logic [WIDTH-1:0]             redirect_pc,
    input  logic                         ras_push,
    input  logic [WIDTH-1:0]             ras_push_addr,
    input  logic                         ras_pop,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_underflow
);

    localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic             pc_valid_q, pc_valid_d;
    logic             ras_underflow_q, ras_underflow_d;
    pc_src_e          pc_src;
    logic [WIDTH-1:0] ras_top;
    logic [CNT_W-1:0] ras_cnt;
    logic             ras_empty;
    logic             ras_push_en;
    logic             ras_pop_en;

    // Sequential successor; wraps modulo 2^WIDTH
    assign pc_next_seq = pc_q + WIDTH'(STEP);
    assign ras_empty   = (ras_cnt == '0);

    // Priority select of the next-pc source
    always_comb begin
        pc_src = HOLD;
        if (pc_valid_q) begin
            if (redirect_valid) begin
                pc_src = REDIRECT;
            end else if (ras_pop && fetch_ready && !ras_empty) begin
                pc_src = RAS;
            end else if (fetch_ready) begin
                pc_src = SEQ;
            end
        end
    end

    // Next pc, valid, underflow pulse and RAS controls
    always_comb begin
        pc_d       = pc_q;
        pc_valid_d = 1'b1;
        case (pc_src)
            REDIRECT: pc_d = redirect_pc;
            RAS:      pc_d = ras_top;
            SEQ:      pc_d = pc_next_seq;
            default:  pc_d = pc_q;
        endcase
        // A pop that loses to a redirect is not an underflow
        ras_underflow_d = pc_valid_q && !redirect_valid && ras_pop &&
                          fetch_ready && ras_empty;
        ras_push_en     = pc_valid_q && ras_push;
        ras_pop_en      = (pc_src == RAS);
    end

    // pc, pc_valid and underflow registers; reset wins over everything
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pc_q            <= RESET_PC;
            pc_valid_q      <= 1'b0;
            ras_underflow_q <= 1'b0;
        end else begin
            pc_q            <= pc_d;
            pc_valid_q      <= pc_valid_d;
            ras_underflow_q <= ras_underflow_d;
        end
    end

    ras_stack #(
        .DEPTH (RAS_DEPTH),
        .WIDTH (WIDTH)
    ) u_ras (
        .clk       (clock),
        .rst_n     (reset_n),
        .push      (ras_push_en),
        .push_data (ras_push_addr),
        .pop       (ras_pop_en),
        .top_data  (ras_top),
        .count     (ras_cnt)
    );

    assign pc            = pc_q;
    assign pc_valid      = pc_valid_q;
    assign ras_count     = ras_cnt;
    assign ras_underflow = ras_underflow_q;

endmodule
